// File: rtl/dcache_sa.sv
// Write-back, write-allocate L1 data cache, 1 or 2 ways with per-set LRU.
// Define DCACHE_PERF_CNT_EN to add the HIT_COUNT/MISS_COUNT/WB_COUNT outputs.
module dcache_sa #(
  parameter int SETS        = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int WAYS        = 2
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [3:0]                  READ,
  input  logic [2:0]                  WRITE,
  input  logic [31:0]                 ADDRESS,
  input  logic [31:0]                 WRITE_DATA,
  output logic [31:0]                 READ_DATA,
  output logic                        BUSY_WAIT,
  output logic                        MEM_READ,
  output logic                        MEM_WRITE,
  output logic [29-$clog2(BLOCK_WORDS):0] MEM_ADDRESS,
  output logic [32*BLOCK_WORDS-1:0]   MEM_WRITE_DATA,
  input  logic [32*BLOCK_WORDS-1:0]   MEM_READ_DATA,
  input  logic                        MEM_BUSY_WAIT
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]                 HIT_COUNT,
  output logic [31:0]                 MISS_COUNT,
  output logic [31:0]                 WB_COUNT
`endif
);
  localparam int OB = 2 + $clog2(BLOCK_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TB = 32 - OB - IB;
  localparam int OW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;
  state_t state_q, state_d;

  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0]           lru_q, lru_d;   // per set: index of the LRU way
  logic                      victim_q, victim_d;
  logic [TB-1:0]             tag_mem  [SETS][WAYS];
  logic [32*BLOCK_WORDS-1:0] data_mem [SETS][WAYS];

  logic          rd_en, wr_en, req, hit, hit_way, vict, fill_en, st_en;
  logic [TB-1:0] tag;
  logic [IB-1:0] idx;
  logic [OW-1:0] off;
  logic [1:0]    bo;
  logic [31:0]   hit_word, ld_data, st_word, wd_rep;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [3:0]    be;

  // simultaneous load and store is treated as no access at all
  assign rd_en = READ[3] & ~WRITE[2];
  assign wr_en = WRITE[2] & ~READ[3];
  assign req   = rd_en | wr_en;
  assign tag   = ADDRESS[31 -: TB];
  assign idx   = ADDRESS[OB +: IB];
  assign off   = (BLOCK_WORDS > 1) ? OW'(ADDRESS >> 2) : '0;
  assign bo    = ADDRESS[1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
        hit     = req;
        hit_way = 1'(w);
      end
  end

  assign hit_word = data_mem[idx][hit_way][off*32 +: 32];

  always_comb begin
    byte_v = hit_word[bo*8 +: 8];
    half_v = hit_word[bo[1]*16 +: 16];
    case (READ[2:0])
      3'b000:  ld_data = {{24{byte_v[7]}}, byte_v};
      3'b001:  ld_data = {{16{half_v[15]}}, half_v};
      3'b100:  ld_data = {24'b0, byte_v};
      3'b101:  ld_data = {16'b0, half_v};
      default: ld_data = hit_word;
    endcase
  end

  assign READ_DATA = (rd_en && hit && !RESET) ? ld_data : '0;
  assign BUSY_WAIT = req && !RESET && (!hit || state_q != IDLE);

  always_comb begin
    case (WRITE[1:0])
      2'b00:   begin be = 4'b0001 << bo;                 wd_rep = {4{WRITE_DATA[7:0]}};  end
      2'b01:   begin be = bo[1] ? 4'b1100 : 4'b0011;     wd_rep = {2{WRITE_DATA[15:0]}}; end
      default: begin be = 4'b1111;                       wd_rep = WRITE_DATA;            end
    endcase
    for (int b = 0; b < 4; b++)
      st_word[b*8 +: 8] = be[b] ? wd_rep[b*8 +: 8] : hit_word[b*8 +: 8];
  end

  // an invalid way is always preferred over the LRU way
  always_comb begin
    if (WAYS == 1)                     vict = 1'b0;
    else if (!valid_q[idx][0])         vict = 1'b0;
    else if (!valid_q[idx][WAYS-1])    vict = 1'b1;
    else                               vict = lru_q[idx];
  end

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    lru_d          = lru_q;
    victim_d       = victim_q;
    fill_en        = 1'b0;
    st_en          = 1'b0;
    MEM_READ       = 1'b0;
    MEM_WRITE      = 1'b0;
    MEM_ADDRESS    = '0;
    MEM_WRITE_DATA = '0;
    case (state_q)
      IDLE:
        if (hit) begin
          lru_d[idx] = ~hit_way;
          if (wr_en) begin
            st_en                 = 1'b1;
            dirty_d[idx][hit_way] = 1'b1;
          end
        end else if (req) begin
          victim_d = vict;
          state_d  = (valid_q[idx][vict] && dirty_q[idx][vict]) ? WRITEBACK : FETCH;
        end
      WRITEBACK: begin
        MEM_WRITE      = 1'b1;
        MEM_ADDRESS    = {tag_mem[idx][victim_q], idx};
        MEM_WRITE_DATA = data_mem[idx][victim_q];
        if (!MEM_BUSY_WAIT) begin
          dirty_d[idx][victim_q] = 1'b0;
          state_d                = FETCH;
        end
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tag, idx};
        if (!MEM_BUSY_WAIT) begin
          fill_en                = 1'b1;
          valid_d[idx][victim_q] = 1'b1;
          dirty_d[idx][victim_q] = 1'b0;
          lru_d[idx]             = ~victim_q;
          state_d                = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      dirty_q  <= '0;
      lru_q    <= '0;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      lru_q    <= lru_d;
      victim_q <= victim_d;
    end
  end

  // line storage is never reset; valid bits guard it
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      data_mem[idx][victim_q] <= MEM_READ_DATA;
      tag_mem[idx][victim_q]  <= tag;
    end else if (st_en) begin
      data_mem[idx][hit_way][off*32 +: 32] <= st_word;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;
  logic        missed_q, missed_d;

  // missed_q marks a request whose final hit completion belongs to a miss
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    missed_d   = missed_q;
    if (state_q == IDLE && hit) begin
      if (missed_q) missed_d  = 1'b0;
      else          hit_cnt_d = hit_cnt_q + 32'd1;
    end else if (state_q == IDLE && req) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
      missed_d   = 1'b1;
    end
    if (state_q == WRITEBACK && !MEM_BUSY_WAIT) wb_cnt_d = wb_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
      missed_q   <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      missed_q   <= missed_d;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
  assign WB_COUNT   = wb_cnt_q;
`endif
endmodule

// File: doc/dcache_sa.md
Name: dcache_sa

Overview:
- Parametrised write-back, write-allocate L1 data cache between the RV32IM MEM stage and the block-wide main-memory model.
- Successor to the fixed 8-set direct-mapped data cache: configurable sets, words per block and associativity (1 or 2 ways, LRU).
- Adds explicit IDLE/WRITEBACK/FETCH sequencing with writeback-then-refill on dirty eviction.
- Reset is asynchronous and clears all line state.

Parameters:
SETS, 8, number of sets; power of two, >=2
BLOCK_WORDS, 4, 32-bit words per line; power of two, >=1
WAYS, 2, associativity; legal values 1 or 2

Ports:
CLK  input  1  clock
RESET  input  1  asynchronous, active-high reset
READ  input  4  [3]=load enable, [2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
WRITE  input  3  [2]=store enable, [1:0]=size (00 SB, 01 SH, 10 SW)
ADDRESS  input  32  byte address
WRITE_DATA  input  32  store data, right-aligned
READ_DATA  output  32  extended load result
BUSY_WAIT  output  1  stall request to pipeline
MEM_READ  output  1  block fetch request
MEM_WRITE  output  1  block writeback request
MEM_ADDRESS  output  32-OB  block address; OB=2+log2(BLOCK_WORDS); 28 at default
MEM_WRITE_DATA  output  32*BLOCK_WORDS  victim line
MEM_READ_DATA  input  32*BLOCK_WORDS  fetched line
MEM_BUSY_WAIT  input  1  memory busy; the transfer completes on the first CLK edge where it is sampled low

Behaviour:
- Address split:
  - offset = ADDRESS[OB-1:2]
  - index = next log2(SETS) bits
  - tag = remainder
  - byte_offset = ADDRESS[1:0]
- Alignment and request legality:
  - LH/LHU/SH ignore ADDRESS[0].
  - LW/SW ignore ADDRESS[1:0].
  - READ[3] and WRITE[2] asserted together is illegal: treated as no access, BUSY_WAIT=0, no state change.
- Per line: valid, dirty, tag, data. Per set (WAYS=2): one LRU bit.
- Hit = request active and some way in the set is valid with a matching tag.
- BUSY_WAIT is combinational: 1 when a request is active and (not hit or state!=IDLE); otherwise 0.
- Load hit:
  - Zero-stall.
  - READ_DATA is combinational from the hit word, byte/half selected by byte_offset, sign- or zero-extended per funct3.
  - READ_DATA=0 when there is no load hit.
- Store hit:
  - Zero-stall.
  - At the posedge, the selected bytes (SB: 1 lane, SH: 2 lanes, SW: all) are merged into the word; line dirty=1.
- LRU (WAYS=2):
  - Hit or fill makes the accessed way MRU.
  - Victim = first invalid way (way0 before way1); otherwise the LRU way.
  - WAYS=1: victim is always way0.
- FSM:
  - IDLE:
    - Miss with a valid and dirty victim -> WRITEBACK.
    - Miss otherwise -> FETCH.
    - Victim way is latched on leaving IDLE.
  - WRITEBACK:
    - MEM_WRITE=1, MEM_ADDRESS={victim tag, index}, MEM_WRITE_DATA=victim line.
    - On an edge with MEM_BUSY_WAIT=0: victim dirty=0 -> FETCH.
  - FETCH:
    - MEM_READ=1, MEM_ADDRESS={tag, index}.
    - On an edge with MEM_BUSY_WAIT=0: line=MEM_READ_DATA, tag written, valid=1, dirty=0, way MRU -> IDLE.
  - The request then hits in IDLE the next cycle. A store applies its merge on that hit edge.
  - The CPU request holds stable while BUSY_WAIT=1. A change of the request mid-miss is not supported.
- Outputs in IDLE: MEM_READ=MEM_WRITE=0; MEM_ADDRESS and MEM_WRITE_DATA are 0.
- Reset, asynchronous and usable mid-operation:
  - State=IDLE; all valid, dirty and LRU bits = 0.
  - MEM_READ=MEM_WRITE=0 immediately; BUSY_WAIT=0; READ_DATA=0.
  - Dirty contents are discarded.
  - Data arrays need not be cleared.

Optional Feature:
DCACHE_PERF_CNT_EN
- Defined:
  - Adds outputs HIT_COUNT[31:0], MISS_COUNT[31:0], WB_COUNT[31:0], all reset to 0.
  - Per request, exactly one of HIT_COUNT or MISS_COUNT increments: HIT_COUNT on the edge an access completes without ever having missed; MISS_COUNT once when leaving IDLE on a miss.
  - WB_COUNT increments on each WRITEBACK completion.
  - All counters wrap at 2^32 without saturating.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, then LW 0x0000_0040 with memory line = {0x44..,0x33..,0x22..,0x11111111} and MEM_BUSY_WAIT low after 3 cycles -> MEM_READ, MEM_ADDRESS=0x0000004; FETCH->IDLE; READ_DATA=0x11111111; BUSY_WAIT drops the cycle after the fill.
2. SB 0xAB to 0x41 after test 1, then LBU 0x41 / LB 0x41 / LW 0x40 -> zero-stall; 0x000000AB / 0xFFFFFFAB / 0x1111AB11; line dirty.
3. WAYS=2: access 0x040, 0x0C0, 0x040, then 0x140 (all set 4) -> 0x0C0 way is evicted (LRU); the next 0x040 access hits with no MEM_READ.
4. Dirty eviction: store 0x040, fill set 4's other way, touch it, access 0x140 -> MEM_WRITE with MEM_ADDRESS=0x0000004 and the modified line, then MEM_READ 0x0000014.
5. Assert RESET during FETCH -> MEM_READ falls with no CLK edge; a re-access of 0x040 misses again.
6. READ[3] and WRITE[2] both high -> BUSY_WAIT=0, no memory activity, cache contents unchanged.
